// File: rtl/if_branch_writeback_pkg.sv
// Shared definitions for the branch-writeback stage, its compare stage and the bench.
// Contents: state encoding, default widths, compare thresholds, result entry type,
// and the reference nested-if condition used by the compare stage.
package if_branch_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LEN    = 16;
    localparam int unsigned DEF_IDX_W  = (DEF_LEN > 1) ? $clog2(DEF_LEN) : 1;

    // Thresholds of the upstream nested-if compare (unsigned 16.16)
    localparam logic [DEF_DATA_W-1:0] COND_TH_A = 32'h0001_0000;
    localparam logic [DEF_DATA_W-1:0] COND_TH_B = 32'h0007_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic [DEF_IDX_W-1:0]  idx;
    } result_t;

    // Condition produced by the compare stage: a above the low threshold and b above the high one
    function automatic logic cond_ref(input logic [DEF_DATA_W-1:0] a,
                                      input logic [DEF_DATA_W-1:0] b);
        return (a > COND_TH_A) && (b > COND_TH_B);
    endfunction

endpackage

// File: rtl/if_branch_writeback_if.sv
// Operand and result streams of the branch-writeback stage.
// Operand side: in_valid/in_ready, array_a_wire_0, array_b_wire_0, if_condition_0.
// Result side : out_valid/out_ready, out_data, out_idx.
// master = producer/consumer around the stage, slave = the stage itself.
interface if_branch_writeback_if import if_branch_pkg::*; #(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IDX_W  = DEF_IDX_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] array_a_wire_0;
    logic [DATA_W-1:0] array_b_wire_0;
    logic              if_condition_0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output in_valid, array_a_wire_0, array_b_wire_0, if_condition_0, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    modport slave (
        input  in_valid, array_a_wire_0, array_b_wire_0, if_condition_0, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/if_branch_writeback_fifo.sv
// Synchronous FIFO with registered occupancy count.
// Ports: clk, reset (async active-low), push/push_data, pop/pop_data_c (show-ahead),
//        count (registered occupancy), empty_c, full_c.
// Push while full is accepted only together with a pop.
module if_branch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data_c,
    output logic [CNT_W-1:0] count,
    output logic             empty_c,
    output logic             full_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_c    = (count == '0);
    assign full_c     = (count == CNT_W'(DEPTH));
    assign do_pop     = pop && !empty_c;
    assign do_push    = push && (!full_c || do_pop);
    assign pop_data_c = mem[rd_ptr];

    // Storage, pointers and occupancy; storage cleared so the read port shows zero after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end
endmodule

// File: rtl/if_branch_writeback.sv
// Branch-writeback stage: takes operand pairs, waits COND_LAT cycles for the compare
// stage's condition, evaluates cond ? a+b : a-b and streams {data, idx} to the array
// writeback through a small FIFO. Exactly LEN elements per start/done transaction.
// Ports: clk, reset (async active-low), start, bus (operand/result streams, slave side),
//        busy (state != IDLE), done (one-cycle pulse at transaction end).
// Build option: define IF_BRANCH_SAT_EN for unsigned saturating add/subtract
// (default build wraps modulo 2^DATA_W).
module if_branch_writeback import if_branch_pkg::*; #(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN        = DEF_LEN,
    parameter int unsigned IDX_W      = (LEN > 1) ? $clog2(LEN) : 1,
    parameter int unsigned COND_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    if_branch_writeback_if.slave bus,
    output logic                 busy,
    output logic                 done
);
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);
    localparam logic [1:0] S_DONE  = 2'(DONE);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CMP_W = $clog2(COND_LAT + FIFO_DEPTH + 1);
    localparam int unsigned ENT_W = DATA_W + IDX_W;
    localparam int unsigned TAIL  = COND_LAT - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [IDX_W-1:0]  acc_cnt;
    logic [IDX_W-1:0]  acc_next;

    logic              dl_valid [COND_LAT];
    logic [DATA_W-1:0] dl_a     [COND_LAT];
    logic [DATA_W-1:0] dl_b     [COND_LAT];
    logic [IDX_W-1:0]  dl_idx   [COND_LAT];

    logic [CMP_W-1:0]  pending;
    logic [CMP_W-1:0]  free_slots;
    logic              in_ready_c;
    logic              accept;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] result;

    logic [ENT_W-1:0]  fifo_out;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    // Credit check: only accept when every pair already in the delay line still has a slot
    always_comb begin
        pending = '0;
        for (int i = 0; i < COND_LAT; i++) begin
            pending = pending + CMP_W'(dl_valid[i]);
        end
        free_slots = CMP_W'(FIFO_DEPTH) - CMP_W'(fifo_count);
        in_ready_c = (state == S_RUN) && (free_slots > pending);
    end

    assign accept       = bus.in_valid && in_ready_c;
    assign bus.in_ready = in_ready_c;

    // Next-state and accept-counter logic
    always_comb begin
        next_state = state;
        acc_next   = acc_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                    acc_next   = '0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    acc_next = acc_cnt + IDX_W'(1);
                    if (acc_cnt == LAST_IDX) begin
                        next_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((pending == '0) && fifo_empty) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            acc_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            acc_cnt <= acc_next;
            busy    <= (next_state != S_IDLE);
            done    <= (next_state == S_DONE);
        end
    end

    // Delay line aligning each pair with its condition; non-accepted cycles travel as bubbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < COND_LAT; i++) begin
                dl_valid[i] <= 1'b0;
                dl_a[i]     <= '0;
                dl_b[i]     <= '0;
                dl_idx[i]   <= '0;
            end
        end else begin
            dl_valid[0] <= accept;
            dl_a[0]     <= bus.array_a_wire_0;
            dl_b[0]     <= bus.array_b_wire_0;
            dl_idx[0]   <= acc_cnt;
            for (int i = 1; i < COND_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_a[i]     <= dl_a[i-1];
                dl_b[i]     <= dl_b[i-1];
                dl_idx[i]   <= dl_idx[i-1];
            end
        end
    end

    // Branch body evaluated on the tail entry
    always_comb begin
        sum  = dl_a[TAIL] + dl_b[TAIL];
        diff = dl_a[TAIL] - dl_b[TAIL];
`ifdef IF_BRANCH_SAT_EN
        if (bus.if_condition_0) begin
            result = (sum < dl_a[TAIL]) ? '1 : sum;
        end else begin
            result = (dl_b[TAIL] > dl_a[TAIL]) ? '0 : diff;
        end
`else
        result = bus.if_condition_0 ? sum : diff;
`endif
    end

    if_branch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (dl_valid[TAIL]),
        .push_data  ({result, dl_idx[TAIL]}),
        .pop        (bus.out_ready),
        .pop_data_c (fifo_out),
        .count      (fifo_count),
        .empty_c    (fifo_empty),
        .full_c     (fifo_full)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_out[ENT_W-1:IDX_W];
    assign bus.out_idx   = fifo_out[IDX_W-1:0];

    // Full flag is implied by the credit check; kept only as a FIFO status output
    logic unused_full;
    assign unused_full = fifo_full;
endmodule
